// File: rtl/multi_thread_pc.sv
// Per-thread program counter bank with round-robin fetch selection and a
// valid/ready fetch port. Optional macro PC_MISALIGN_EN enables sticky misalign trapping.
module multi_thread_pc #(
    parameter int unsigned            XLEN         = 32,
    parameter int unsigned            NUM_THREADS  = 4,
    parameter int unsigned            TID_W        = $clog2(NUM_THREADS),
    parameter logic [XLEN-1:0]        RESET_VECTOR = '0,
    parameter logic [NUM_THREADS-1:0] RESET_MASK   = NUM_THREADS'(1),
    parameter int unsigned            INC          = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startValid,
    input  logic [TID_W-1:0]       startThread,
    input  logic [XLEN-1:0]        startPc,
    input  logic                   redirectValid,
    input  logic [TID_W-1:0]       redirectThread,
    input  logic [XLEN-1:0]        redirectPc,
    input  logic                   haltValid,
    input  logic [TID_W-1:0]       haltThread,
    input  logic                   fetchReady,
    output logic                   fetchValid,
    output logic [TID_W-1:0]       fetchThread,
    output logic [XLEN-1:0]        fetchPc,
    output logic [XLEN-1:0]        fetchPrevPc,
    output logic [NUM_THREADS-1:0] activeMask,
    output logic [NUM_THREADS-1:0] misaligned
);

    logic [XLEN-1:0]        r_pc     [NUM_THREADS];
    logic [XLEN-1:0]        r_prevPc [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_activeMask;
    logic [TID_W-1:0]       r_rrPtr;

    logic [TID_W-1:0]       w_sel;
    logic [TID_W-1:0]       w_idx;
    logic                   w_found;
    logic                   w_accept;

    logic [NUM_THREADS-1:0] w_haltHit;
    logic [NUM_THREADS-1:0] w_redirHit;
    logic [NUM_THREADS-1:0] w_startHit;
    logic [NUM_THREADS-1:0] w_incHit;
    logic [XLEN-1:0]        w_target [NUM_THREADS];

    // First active thread at or after the round-robin pointer, wrapping.
    always_comb begin
        w_sel   = r_rrPtr;
        w_idx   = r_rrPtr;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_THREADS; k++) begin
            w_idx = r_rrPtr + TID_W'(k);
            if (!w_found && r_activeMask[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign fetchValid  = |r_activeMask;
    assign fetchThread = w_sel;
    assign fetchPc     = r_pc[w_sel];
    assign fetchPrevPc = r_prevPc[w_sel];
    assign activeMask  = r_activeMask;
    assign w_accept    = fetchValid && fetchReady;

    // Per-thread event decode: halt > redirect > start > fetch increment.
    always_comb begin
        w_haltHit  = '0;
        w_redirHit = '0;
        w_startHit = '0;
        w_incHit   = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            w_haltHit[i]  = haltValid && (haltThread == TID_W'(i));
            w_redirHit[i] = !w_haltHit[i] && redirectValid &&
                            (redirectThread == TID_W'(i));
            w_startHit[i] = !w_haltHit[i] && !w_redirHit[i] && startValid &&
                            (startThread == TID_W'(i));
            w_incHit[i]   = !w_haltHit[i] && !w_redirHit[i] && !w_startHit[i] &&
                            w_accept && (w_sel == TID_W'(i));
            w_target[i]   = w_redirHit[i] ? redirectPc : startPc;
        end
    end

`ifdef PC_MISALIGN_EN
    logic [NUM_THREADS-1:0] r_misaligned;
    assign misaligned = r_misaligned;
`else
    assign misaligned = '0;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                r_pc[i]     <= RESET_VECTOR;
                r_prevPc[i] <= RESET_VECTOR;
            end
            r_activeMask <= RESET_MASK;
            r_rrPtr      <= '0;
`ifdef PC_MISALIGN_EN
            r_misaligned <= '0;
`endif
        end else begin
            // The pointer advances on any accept, even if the thread was halted or redirected.
            if (w_accept) begin
                r_rrPtr <= w_sel + TID_W'(1);
            end
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                if (w_haltHit[i]) begin
                    r_activeMask[i] <= 1'b0;
                end else if (w_redirHit[i] || w_startHit[i]) begin
                    r_pc[i]     <= w_target[i];
                    r_prevPc[i] <= r_pc[i];
`ifdef PC_MISALIGN_EN
                    if (w_target[i][1:0] != 2'b00) begin
                        r_misaligned[i] <= 1'b1;
                        r_activeMask[i] <= 1'b0;
                    end else if (w_startHit[i]) begin
                        r_activeMask[i] <= 1'b1;
                    end
`else
                    if (w_startHit[i]) begin
                        r_activeMask[i] <= 1'b1;
                    end
`endif
                end else if (w_incHit[i]) begin
                    r_pc[i]     <= r_pc[i] + XLEN'(INC);
                    r_prevPc[i] <= r_pc[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_thread_pc.sv
// Bench for multi_thread_pc: directed vector table followed by random commands
// checked against an array-based reference model (honours PC_MISALIGN_EN).
module tb_multi_thread_pc;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startValid;
    logic [1:0]  startThread;
    logic [31:0] startPc;
    logic        redirectValid;
    logic [1:0]  redirectThread;
    logic [31:0] redirectPc;
    logic        haltValid;
    logic [1:0]  haltThread;
    logic        fetchReady;
    logic        fetchValid;
    logic [1:0]  fetchThread;
    logic [31:0] fetchPc;
    logic [31:0] fetchPrevPc;
    logic [3:0]  activeMask;
    logic [3:0]  misaligned;

    always #5 clk = ~clk;

    multi_thread_pc #(
        .XLEN         (32),
        .NUM_THREADS  (4),
        .RESET_VECTOR (32'h0000_0100),
        .RESET_MASK   (4'b0001),
        .INC          (4)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startValid     (startValid),
        .startThread    (startThread),
        .startPc        (startPc),
        .redirectValid  (redirectValid),
        .redirectThread (redirectThread),
        .redirectPc     (redirectPc),
        .haltValid      (haltValid),
        .haltThread     (haltThread),
        .fetchReady     (fetchReady),
        .fetchValid     (fetchValid),
        .fetchThread    (fetchThread),
        .fetchPc        (fetchPc),
        .fetchPrevPc    (fetchPrevPc),
        .activeMask     (activeMask),
        .misaligned     (misaligned)
    );

    typedef struct {
        bit          rst;
        bit          sv;  logic [1:0] st; logic [31:0] spc;
        bit          rv;  logic [1:0] rt; logic [31:0] rpc;
        bit          hv;  logic [1:0] ht;
        bit          rdy;
        bit          chk;
        bit          ev;  logic [1:0] eth; logic [31:0] epc; logic [31:0] eprev;
        logic [3:0]  emask;
        logic [3:0]  emis;
    } vec_t;

    vec_t tab[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state
    logic [31:0] m_pc [4];
    logic [31:0] m_prev [4];
    logic [3:0]  m_mask;
    logic [3:0]  m_mis;
    int          m_rr;
    bit          m_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick();
        for (int k = 0; k < 4; k++)
            if (m_mask[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return -1;
    endfunction

    task automatic m_step(input vec_t v);
        logic [31:0] n_pc [4];
        logic [31:0] n_prev [4];
        logic [3:0]  n_mask;
        logic [31:0] tgt;
        int sel;
        bit acc;
        if (v.rst) begin
            for (int t = 0; t < 4; t++) begin
                m_pc[t] = 32'h100; m_prev[t] = 32'h100;
            end
            m_mask = 4'b0001; m_mis = 4'b0000; m_rr = 0; m_ok = 1;
            return;
        end
        sel = m_pick();
        acc = (sel >= 0) && v.rdy;
        n_pc = m_pc; n_prev = m_prev; n_mask = m_mask;
        for (int t = 0; t < 4; t++) begin
            if (v.hv && v.ht == t) begin
                n_mask[t] = 1'b0;
            end else if ((v.rv && v.rt == t) || (v.sv && v.st == t)) begin
                tgt = (v.rv && v.rt == t) ? v.rpc : v.spc;
                n_pc[t] = tgt; n_prev[t] = m_pc[t];
                if (!(v.rv && v.rt == t)) n_mask[t] = 1'b1;
`ifdef PC_MISALIGN_EN
                if (tgt % 4 != 0) begin
                    m_mis[t] = 1'b1; n_mask[t] = 1'b0;
                end
`endif
            end else if (acc && sel == t) begin
                n_pc[t] = m_pc[t] + 32'd4; n_prev[t] = m_pc[t];
            end
        end
        if (acc) m_rr = (sel + 1) % 4;
        m_pc = n_pc; m_prev = n_prev; m_mask = n_mask;
    endtask

    task automatic apply(input vec_t v);
        int sel;
        @(negedge clk);
        resetN         = !v.rst;
        startValid     = v.sv;  startThread    = v.st; startPc    = v.spc;
        redirectValid  = v.rv;  redirectThread = v.rt; redirectPc = v.rpc;
        haltValid      = v.hv;  haltThread     = v.ht;
        fetchReady     = v.rdy;
        #1;
        if (m_ok) begin
            sel = m_pick();
            chk("model_valid", {31'b0, fetchValid}, {31'b0, sel >= 0});
            chk("model_mask", {28'b0, activeMask}, {28'b0, m_mask});
            chk("model_misaligned", {28'b0, misaligned}, {28'b0, m_mis});
            if (sel >= 0) begin
                chk("model_thread", {30'b0, fetchThread}, sel);
                chk("model_pc", fetchPc, m_pc[sel]);
                chk("model_prevpc", fetchPrevPc, m_prev[sel]);
            end
        end
        if (v.chk) begin
            chk("tab_valid", {31'b0, fetchValid}, {31'b0, v.ev});
            chk("tab_mask", {28'b0, activeMask}, {28'b0, v.emask});
            chk("tab_misaligned", {28'b0, misaligned}, {28'b0, v.emis});
            if (v.ev) begin
                chk("tab_thread", {30'b0, fetchThread}, {30'b0, v.eth});
                chk("tab_pc", fetchPc, v.epc);
                chk("tab_prevpc", fetchPrevPc, v.eprev);
            end
        end
        m_step(v);
    endtask

    function automatic logic [31:0] rnd_pc();
        int r = $urandom_range(0, 7);
        if (r == 0) return $urandom | 32'h1;
        if (r == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    initial begin
        vec_t v;
        // rst sv st spc  rv rt rpc  hv ht  rdy chk  ev eth epc eprev emask emis
        tab.push_back('{1, 0,0,0, 0,0,0, 0,0, 0, 0, 0,0,0,0, 4'b0000, 4'b0000});
        tab.push_back('{1, 0,0,0, 0,0,0, 0,0, 0, 0, 0,0,0,0, 4'b0000, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'h100,32'h100, 4'b0001, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'h104,32'h100, 4'b0001, 4'b0000});
        tab.push_back('{0, 1,1,32'h2000, 0,0,0, 0,0, 0, 1, 1,0,32'h108,32'h104, 4'b0001, 4'b0000});
        tab.push_back('{0, 1,2,32'h3000, 0,0,0, 0,0, 0, 1, 1,1,32'h2000,32'h100, 4'b0011, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,1,32'h2000,32'h100, 4'b0111, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,2,32'h3000,32'h100, 4'b0111, 4'b0000});
        tab.push_back('{0, 0,0,0, 1,0,32'h400, 0,0, 1, 1, 1,0,32'h108,32'h104, 4'b0111, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,1,32'h2004,32'h2000, 4'b0111, 4'b0000});
        for (int i = 0; i < 3; i++)
            tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 0, 1, 1,2,32'h3004,32'h3000, 4'b0111, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 1,1, 0, 1, 1,2,32'h3004,32'h3000, 4'b0111, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,2,32'h3004,32'h3000, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'h400,32'h108, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,2,32'h3008,32'h3004, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 1,0,32'hFFFF_FFFC, 0,0, 0, 1, 1,0,32'h404,32'h400, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'hFFFF_FFFC,32'h404, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,2,32'h300C,32'h3008, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'h0,32'hFFFF_FFFC, 4'b0101, 4'b0000});
        tab.push_back('{0, 0,0,0, 1,2,32'h3002, 0,0, 0, 1, 1,2,32'h3010,32'h300C, 4'b0101, 4'b0000});
`ifdef PC_MISALIGN_EN
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 0, 1, 1,0,32'h4,32'h0, 4'b0001, 4'b0100});
        tab.push_back('{1, 0,0,0, 0,0,0, 0,0, 0, 1, 1,0,32'h4,32'h0, 4'b0001, 4'b0100});
`else
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 0, 1, 1,2,32'h3002,32'h3010, 4'b0101, 4'b0000});
        tab.push_back('{1, 0,0,0, 0,0,0, 0,0, 0, 1, 1,2,32'h3002,32'h3010, 4'b0101, 4'b0000});
`endif
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 0, 1, 1,0,32'h100,32'h100, 4'b0001, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'h100,32'h100, 4'b0001, 4'b0000});
        tab.push_back('{0, 0,0,0, 0,0,0, 0,0, 1, 1, 1,0,32'h104,32'h100, 4'b0001, 4'b0000});

        foreach (tab[i]) apply(tab[i]);

        // Same-cycle corner cases: halt+accept, redirect+halt, start of running thread
        v = '{0, 0,0,0, 0,0,0, 1,0, 1, 0, 0,0,0,0, 4'b0000, 4'b0000};
        apply(v);
        v = '{0, 1,0,32'h500, 0,0,0, 0,0, 1, 0, 0,0,0,0, 4'b0000, 4'b0000};
        apply(v);
        v = '{0, 1,0,32'h600, 1,0,32'h700, 1,0, 1, 0, 0,0,0,0, 4'b0000, 4'b0000};
        apply(v);
        v = '{0, 1,3,32'h800, 0,0,0, 0,0, 1, 0, 0,0,0,0, 4'b0000, 4'b0000};
        apply(v);
        v = '{0, 1,3,32'h900, 1,1,32'hA00, 0,0, 1, 0, 0,0,0,0, 4'b0000, 4'b0000};
        apply(v);

        for (int n = 0; n < 3000; n++) begin
            v.rst = ($urandom_range(0, 399) == 0);
            v.sv  = ($urandom_range(0, 3) == 0); v.st = 2'($urandom); v.spc = rnd_pc();
            v.rv  = ($urandom_range(0, 4) == 0); v.rt = 2'($urandom); v.rpc = rnd_pc();
            v.hv  = ($urandom_range(0, 6) == 0); v.ht = 2'($urandom);
            v.rdy = ($urandom_range(0, 3) != 0);
            v.chk = 0; v.ev = 0; v.eth = 0; v.epc = 0; v.eprev = 0;
            v.emask = 0; v.emis = 0;
            apply(v);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_thread_pc.md
Name: multi_thread_pc

Overview:
- Parametrised program counter bank for the shader core; one PC / previous-PC pair per hardware thread (warp slot).
- Round-robin selects one active thread per cycle and presents its PC to instruction fetch over a valid/ready handshake.
- Accepts per-thread start, redirect (branch/jump) and halt commands from the dispatcher and execute stage.
- Replaces the single-thread counter in the multi-thread core.

Parameters:
- XLEN, 32, PC and data width in bits.
- NUM_THREADS, 4, thread slots; power of two, 2..16.
- TID_W, $clog2(NUM_THREADS), thread id width (derived).
- RESET_VECTOR, 32'h0000_0000, reset value of every PC and prevPc.
- RESET_MASK, 1, activeMask value at reset (thread 0 running).
- INC, 4, PC increment per accepted fetch.

Ports:
- clk  in  1  clock; all state changes on posedge.
- resetN  in  1  synchronous, active-low reset.
- startValid  in  1  start-thread command.
- startThread  in  TID_W  thread to start.
- startPc  in  XLEN  entry PC.
- redirectValid  in  1  branch/jump redirect.
- redirectThread  in  TID_W  thread redirected.
- redirectPc  in  XLEN  target PC.
- haltValid  in  1  halt command.
- haltThread  in  TID_W  thread halted.
- fetchReady  in  1  fetch stage accepts request.
- fetchValid  out  1  request available.
- fetchThread  out  TID_W  selected thread.
- fetchPc  out  XLEN  PC of selected thread.
- fetchPrevPc  out  XLEN  prevPc of selected thread.
- activeMask  out  NUM_THREADS  running threads.
- misaligned  out  NUM_THREADS  sticky misalign flags; only when PC_MISALIGN_EN is defined, otherwise tied 0.

Behaviour:
- Reset (resetN=0 at posedge):
  - All pc[i] and prevPc[i] = RESET_VECTOR.
  - activeMask = RESET_MASK, rrPtr = 0, misaligned = 0.
  - Outputs are therefore valid the cycle after reset deasserts.
  - Reset overrides every command in the same cycle, including mid-handshake.
- Selection (combinational from registers):
  - fetchThread = first set bit of activeMask scanning rrPtr, rrPtr+1, ... modulo NUM_THREADS.
  - fetchValid = |activeMask.
  - fetchPc = pc[fetchThread] and fetchPrevPc = prevPc[fetchThread]. Zero-latency, no pipeline register.
- Accept (fetchValid & fetchReady):
  - pc[t] <= pc[t] + INC, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
  - prevPc[t] <= pc[t].
  - rrPtr <= t + 1 (mod NUM_THREADS).
- Stall (fetchValid & !fetchReady): rrPtr, selection, fetchPc and fetchPrevPc hold, except for the commands below.
- Redirect to thread t: pc[t] <= redirectPc and prevPc[t] <= pc[t]. activeMask is unchanged; redirecting a halted thread updates its PC but does not start it.
- Start to thread t: pc[t] <= startPc, prevPc[t] <= pc[t], activeMask[t] <= 1. Starting an already running thread acts as a redirect.
- Halt to thread t: activeMask[t] <= 0; pc and prevPc hold. If t was the stalled selection, the selection moves next cycle; fetch must tolerate the withdrawn request.
- Priority when several events hit the same thread in one cycle: halt > redirect > start > fetch increment. The loser has no effect on that thread.
  - Redirect plus accept of the same thread: pc <= redirectPc, prevPc <= old pc, rrPtr still advances.
  - Halt plus accept of the same thread: the fetch is consumed, rrPtr advances, pc does not increment.
- Commands to different threads in the same cycle are all applied independently.
- No active threads: fetchValid=0 and fetchThread/fetchPc are don't-care; the bench must not check them.

Optional Feature:
- Macro PC_MISALIGN_EN.
- Defined: a redirect or start whose target has bits[1:0] != 0 sets misaligned[t] (sticky until reset) and clears activeMask[t]; pc[t] is loaded with the target for debug.
- Not defined: targets are loaded unchecked and misaligned is constant 0.

Test Plan:
- Reset release, RESET_VECTOR=0x100, fetchReady=1 for 3 cycles -> fetchPc 0x100, 0x104, 0x108 on thread 0; fetchPrevPc lags by one fetch.
- Start threads 1 and 2 at 0x2000 and 0x3000, fetchReady=1 -> thread order 0,1,2,0,1,2; each thread's PC advances by 4 per own issue.
- fetchReady=0 for 5 cycles with threads 0..2 active -> fetchThread, fetchPc and fetchPrevPc stable; first accept after release uses the same thread.
- Redirect thread 0 to 0x400 in the same cycle it is accepted at 0x108 -> next pc[0]=0x400, prevPc[0]=0x108; halt thread 1 -> thread 1 is skipped from the next cycle.
- Thread at PC 0xFFFF_FFFC accepted -> pc wraps to 0x0; resetN=0 asserted mid-stall -> all PCs = RESET_VECTOR and activeMask = RESET_MASK on the next cycle.
- PC_MISALIGN_EN defined, redirect thread 2 to 0x3002 -> misaligned[2]=1, activeMask[2]=0; macro undefined -> thread 2 is fetched at 0x3002.
